fpmul_arbiter: RTL

FPMUL_ARBITER -- requirements
Module: fpmul_arbiter

---
 rtl/fpmul_pkg.sv | 29 ++
 rtl/rr_arbiter.sv | 38 +++
 rtl/fpmul_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/fpmul_pkg.sv
// rtl/fpmul_pkg.sv - shared state type and constant helpers for the fpmul arbiter
package fpmul_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } arb_state_t;

    localparam int MAX_W = 256;

    function automatic int op_width(input int log_bit);
        return 2 ** log_bit;
    endfunction

    // Exponent field plus mantissa MSB form one contiguous run of ones below the sign bit.
    function automatic logic [MAX_W-1:0] qnan_pattern(input int w, input int exp_bit);
        logic [MAX_W-1:0] p;
        p = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if ((i >= w - 2 - exp_bit) && (i <= w - 2)) begin
                p[i] = 1'b1;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin winner search from a start index
module rr_arbiter #(
    parameter int  N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] start,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_any
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] pos;

    // Scan offsets from farthest to nearest so the nearest active requester wins last.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        sum       = '0;
        pos       = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            sum = {1'b0, start} + (IDX_W + 1)'(i);
            if (sum >= (IDX_W + 1)'(N_REQ)) begin
                sum = sum - (IDX_W + 1)'(N_REQ);
            end
            pos = sum[IDX_W-1:0];
            if (req[pos]) begin
                grant      = '0;
                grant[pos] = 1'b1;
                grant_idx  = pos;
                grant_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpmul_arbiter.sv
// rtl/fpmul_arbiter.sv - round-robin front end sharing one external fpmul among N_REQ requesters
module fpmul_arbiter
    import fpmul_pkg::*;
#(
    parameter int  N_REQ   = 4,
    parameter int  LOG_BIT = 6,
    parameter int  EXP_BIT = 11,
    parameter int  TIMEOUT = 255,
    localparam int W       = op_width(LOG_BIT),
    localparam int IDX_W   = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ-1:0][W-1:0] req_a,
    input  logic [N_REQ-1:0][W-1:0] req_b,
    output logic [N_REQ-1:0]        req_ready,
    output logic [N_REQ-1:0]        resp_valid,
    output logic [W-1:0]            resp_out,
    output logic                    resp_err,
    output logic [W-1:0]            mul_a,
    output logic [W-1:0]            mul_b,
    output logic                    mul_start,
    input  logic [W-1:0]            mul_out,
    input  logic                    mul_ready
);

    localparam int               CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [MAX_W-1:0] NAN_FULL  = qnan_pattern(W, EXP_BIT);
    localparam logic [W-1:0]     NAN_VALUE = NAN_FULL[W-1:0];
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0  = N_REQ'(1);

    arb_state_t       state;
    arb_state_t       state_next;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] last_owner;
    logic [IDX_W-1:0] search_start;
    logic [IDX_W-1:0] win_idx;
    logic [N_REQ-1:0] win_grant;
    logic             win_any;
    logic [CNT_W-1:0] wait_cnt;
    logic             wait_ok;
    logic             wait_timeout;

    assign search_start = (last_owner == LAST_IDX) ? '0 : last_owner + IDX_W'(1);

    rr_arbiter #(
        .N_REQ(N_REQ)
    ) u_rr (
        .req      (req_valid),
        .start    (search_start),
        .grant    (win_grant),
        .grant_idx(win_idx),
        .grant_any(win_any)
    );

    assign req_ready = (state == S_IDLE && !rst) ? win_grant : '0;

    // A zero count marks the first WAIT cycle, where a leftover idle-ready is not trusted.
    assign wait_ok      = (state == S_WAIT) && (wait_cnt != '0) && mul_ready;
    assign wait_timeout = (state == S_WAIT) && !wait_ok && (wait_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (win_any) state_next = S_ISSUE;
            S_ISSUE: state_next = S_WAIT;
            S_WAIT:  if (wait_ok || wait_timeout) state_next = S_RESP;
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner      <= '0;
            last_owner <= LAST_IDX;
            wait_cnt   <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
            mul_start  <= 1'b0;
            resp_valid <= '0;
            resp_out   <= '0;
            resp_err   <= 1'b0;
        end else begin
            mul_start  <= 1'b0;
            resp_valid <= '0;
            case (state)
                S_IDLE: begin
                    if (win_any) begin
                        mul_a      <= req_a[win_idx];
                        mul_b      <= req_b[win_idx];
                        owner      <= win_idx;
                        last_owner <= win_idx;
                        mul_start  <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= '0;
                end
                S_WAIT: begin
                    if (wait_ok) begin
                        resp_out   <= mul_out;
                        resp_err   <= 1'b0;
                        resp_valid <= ONE_HOT0 << owner;
                    end else if (wait_timeout) begin
                        resp_out   <= NAN_VALUE;
                        resp_err   <= 1'b1;
                        resp_valid <= ONE_HOT0 << owner;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
